// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM state codes, working-state struct, round constants,
// the standard initial hash value and the FIPS 180-4 logical functions.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_PAD  = 3'b010,
        ST_HASH = 3'b011,
        ST_DONE = 3'b100
    } state_e;

    // Packed so that a sits in [255:224], matching the H0..H7 digest layout.
    typedef struct packed {
        logic [31:0] a, b, c, d, e, f, g, h;
    } work_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic work_t add_work(input work_t x, input work_t y);
        work_t r;
        r.a = x.a + y.a;  r.b = x.b + y.b;  r.c = x.c + y.c;  r.d = x.d + y.d;
        r.e = x.e + y.e;  r.f = x.f + y.f;  r.g = x.g + y.g;  r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: (a..h, W[t], K[t]) -> (a'..h').
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       cur_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output work_t       nxt_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = cur_i.h + bsig1(cur_i.e) + ch(cur_i.e, cur_i.f, cur_i.g) + k_i + w_i;
        t2 = bsig0(cur_i.a) + maj(cur_i.a, cur_i.b, cur_i.c);
        nxt_o.a = t1 + t2;
        nxt_o.b = cur_i.a;
        nxt_o.c = cur_i.b;
        nxt_o.d = cur_i.c;
        nxt_o.e = cur_i.d + t1;
        nxt_o.f = cur_i.e;
        nxt_o.g = cur_i.f;
        nxt_o.h = cur_i.g;
    end

endmodule

// File: rtl/sha256_mining_core.sv
// SHA-256 mining core: word loader, padding-on-read, 65-cycle-per-block compression.
// Optional SHA256_MIDSTATE_EN adds h_init to replace the standard IV.
module sha256_mining_core
    import sha256_pkg::*;
#(
    parameter int MAX_BLOCKS = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         stopw,
    input  logic [6:0]   indirizzo,
    input  logic [31:0]  message,
    input  logic [14:0]  mess_lenght,
`ifdef SHA256_MIDSTATE_EN
    input  logic [255:0] h_init,
`endif
    output logic [2:0]   state,
    output logic         fine,
    output logic [255:0] HASH
);

    localparam int BW    = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
    localparam int AW    = BW + 4;
    localparam int DEPTH = MAX_BLOCKS * 16;

    state_e        state_q;
    logic          fine_q;
    logic [255:0]  hash_q;
    logic [3:0]    wc_q;
    logic [31:0]   buf_q [DEPTH];

    logic [14:0]   len_q;
    logic [BW-1:0] blk_q, last_blk_q, last_blk_d;
    logic [6:0]    t_q;
    work_t         work_q, digest_q, round_d, sum_d, init_st;
    logic [31:0]   win_q [16];

    logic          wr_en, last_blk;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [31:0]   raw_w, pad_w, sched_w, w_d, len32, bit_base, nblk;
    logic [4:0]    off;

`ifdef SHA256_MIDSTATE_EN
    assign init_st = work_t'(h_init);
`else
    assign init_st = work_t'(IV);
`endif

    assign wr_en    = reset && (state_q == ST_LOAD) && !stopw && ({25'b0, indirizzo} < 32'(MAX_BLOCKS));
    assign wr_addr  = AW'({indirizzo, wc_q});
    assign rd_addr  = {blk_q, t_q[3:0]};
    assign raw_w    = buf_q[rd_addr];
    assign last_blk = (blk_q == last_blk_q);
    assign sum_d    = add_work(digest_q, work_q);

    // Bits below L pass through, bit L reads as 1, everything after reads as 0;
    // the last block's words 14/15 carry the 64-bit length instead.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        pad_w    = '0;
        len32    = {17'b0, len_q};
        bit_base = 32'({rd_addr, 5'b0});
        off      = 5'(len32 - bit_base);
        if (len32 >= bit_base + 32'd32)
            pad_w = raw_w;
        else if (len32 >= bit_base)
            pad_w = (raw_w & ~(32'hFFFF_FFFF >> off)) | (32'h8000_0000 >> off);
        if (last_blk && t_q[3:0] == 4'd14)
            pad_w = '0;
        else if (last_blk && t_q[3:0] == 4'd15)
            pad_w = len32;
    end

    assign sched_w = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
    assign w_d     = (t_q < 7'd16) ? pad_w : sched_w;

    always_comb begin
        nblk = ({16'b0, {1'b0, mess_lenght} + 16'd64} >> 9) + 32'd1;
        if (nblk > 32'(MAX_BLOCKS))
            nblk = 32'(MAX_BLOCKS);
        last_blk_d = BW'(nblk - 32'd1);
    end

    sha256_round u_round (
        .cur_i (work_q),
        .w_i   (w_d),
        .k_i   (K[t_q[5:0]]),
        .nxt_o (round_d)
    );

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q <= ST_IDLE;
            fine_q  <= 1'b0;
            hash_q  <= '0;
            wc_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start && !stopw) begin
                    state_q <= ST_LOAD;
                    wc_q    <= '0;
                end
                ST_LOAD: begin
                    if (stopw) state_q <= ST_PAD;
                    else       wc_q    <= wc_q + 4'd1;
                end
                ST_PAD:  state_q <= ST_HASH;
                ST_HASH: if (t_q == 7'd64 && last_blk) begin
                    state_q <= ST_DONE;
                    fine_q  <= 1'b1;
                    hash_q  <= sum_d;
                end
                ST_DONE: if (!start) begin
                    state_q <= ST_IDLE;
                    fine_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the message buffer and datapath registers carry no reset; padding masks stale words and PAD reloads the rest.
    always_ff @(posedge clock) begin
        if (wr_en)
            buf_q[wr_addr] <= message;
    end

    always_ff @(posedge clock) begin
        if (state_q == ST_PAD) begin
            len_q      <= mess_lenght;
            last_blk_q <= last_blk_d;
            blk_q      <= '0;
            t_q        <= '0;
            work_q     <= init_st;
            digest_q   <= init_st;
        end else if (state_q == ST_HASH) begin
            if (t_q == 7'd64) begin
                digest_q <= sum_d;
                work_q   <= sum_d;
                t_q      <= '0;
                blk_q    <= blk_q + BW'(1);
            end else begin
                work_q <= round_d;
                t_q    <= t_q + 7'd1;
                for (int i = 0; i < 15; i++)
                    win_q[i] <= win_q[i + 1];
                win_q[15] <= w_d;
            end
        end
    end

    assign state = state_q;
    assign fine  = fine_q;
    assign HASH  = hash_q;

endmodule

// File: tb/tb_sha256_mining_core.sv
// Self-checking bench for sha256_mining_core: known digests plus randomized messages
// against a bit-level SHA-256 reference model. Honours SHA256_MIDSTATE_EN if defined.
module tb_sha256_mining_core;
    import sha256_pkg::*;

    localparam int MAXB = 4;

    logic         clock = 1'b0;
    logic         reset, start, stopw;
    logic [6:0]   indirizzo;
    logic [31:0]  message;
    logic [14:0]  mess_lenght;
    logic [2:0]   state;
    logic         fine;
    logic [255:0] HASH;
`ifdef SHA256_MIDSTATE_EN
    logic [255:0] h_init = IV;
`endif

    sha256_mining_core #(.MAX_BLOCKS(MAXB)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stopw       (stopw),
        .indirizzo   (indirizzo),
        .message     (message),
        .mess_lenght (mess_lenght),
`ifdef SHA256_MIDSTATE_EN
        .h_init      (h_init),
`endif
        .state       (state),
        .fine        (fine),
        .HASH        (HASH)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] msg_w [64];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic int blocks_for(input int len);
        int nb = (len + 64) / 512 + 1;
        return (nb > MAXB) ? MAXB : nb;
    endfunction

    // Reference: build the padded bit stream bit by bit, then run textbook compression.
    function automatic logic [255:0] ref_hash(input int len);
        logic [31:0] m [64];
        logic [31:0] w [64];
        logic [31:0] h [8];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        logic [255:0] init;
        int nb = blocks_for(len);
`ifdef SHA256_MIDSTATE_EN
        init = h_init;
`else
        init = IV;
`endif
        for (int i = 0; i < 64; i++) m[i] = '0;
        for (int i = 0; i < nb * 512; i++) begin
            if (i < len)       m[i / 32][31 - i % 32] = msg_w[i / 32][31 - i % 32];
            else if (i == len) m[i / 32][31 - i % 32] = 1'b1;
        end
        m[nb * 16 - 2] = '0;
        m[nb * 16 - 1] = 32'(len);
        for (int j = 0; j < 8; j++) h[j] = init[255 - 32 * j -: 32];
        for (int blk = 0; blk < nb; blk++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) w[t] = m[blk * 16 + t];
                else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                          + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            end
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
                t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    // Drives one LOAD phase and leaves the DUT freshly in PAD (checked).
    task automatic load_msg(input string tag, input int len, input int nw, input bit bad_wr);
        @(negedge clock);
        start = 1'b1; stopw = 1'b0; mess_lenght = 15'(len);
        @(negedge clock);
        chk({tag, ":load"}, 256'(state), 256'(3'b001));
        for (int k = 0; k < nw; k++) begin
            indirizzo = 7'(k / 16); message = msg_w[k];
            @(negedge clock);
        end
        if (bad_wr) begin
            // Out-of-range block whose truncated address aliases an already-written word.
            indirizzo = 7'(MAXB); message = $urandom;
            @(negedge clock);
        end
        stopw = 1'b1; message = $urandom;
        @(negedge clock);
        stopw = 1'b0;
        chk({tag, ":pad"}, 256'(state), 256'(3'b010));
    endtask

    task automatic finish_msg(input string tag, input int len, input bit drop_start,
                              input bit do_hash, input logic [255:0] exp);
        int cyc = 0;
        if (drop_start) start = 1'b0;
        while (state !== 3'b100 && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
        chk({tag, ":cycles"}, 256'(cyc), 256'(1 + 65 * blocks_for(len)));
        chk({tag, ":fine"}, 256'(fine), 256'(1));
        if (do_hash) chk({tag, ":hash"}, HASH, exp);
        start = 1'b0;
        @(negedge clock);
        chk({tag, ":idle"}, 256'(state), 256'(3'b000));
        chk({tag, ":fine_low"}, 256'(fine), 256'(0));
        if (do_hash) chk({tag, ":held"}, HASH, exp);
    endtask

    task automatic run_rand(input string tag, input int len, input bit drop_start);
        int nw;
        logic [255:0] exp;
        for (int i = 0; i < 64; i++) msg_w[i] = $urandom;
        nw = (len + 31) / 32 + $urandom_range(0, 2);
        if (nw > 64) nw = 64;
        exp = ref_hash(len);
        load_msg(tag, len, nw, 1'b1);
        finish_msg(tag, len, drop_start, 1'b1, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; stopw = 1'b0;
        indirizzo = '0; message = '0; mess_lenght = '0;
        repeat (2) @(negedge clock);
        chk("rst:state", 256'(state), 256'(0));
        chk("rst:fine", 256'(fine), 256'(0));
        chk("rst:hash", HASH, 256'(0));
        reset = 1'b1;

        load_msg("empty", 0, 0, 1'b0);
        finish_msg("empty", 0, 1'b0, 1'b1,
                   256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        msg_w[0] = 32'h61626300;
        load_msg("abc", 24, 1, 1'b0);
        finish_msg("abc", 24, 1'b0, 1'b1,
                   256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        msg_w[0] = 32'h616263FF;
        load_msg("abc_garbage", 24, 1, 1'b0);
        finish_msg("abc_garbage", 24, 1'b0, 1'b1,
                   256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        msg_w[0]  = 32'h61626364; msg_w[1]  = 32'h62636465; msg_w[2]  = 32'h63646566;
        msg_w[3]  = 32'h64656667; msg_w[4]  = 32'h65666768; msg_w[5]  = 32'h66676869;
        msg_w[6]  = 32'h6768696a; msg_w[7]  = 32'h68696a6b; msg_w[8]  = 32'h696a6b6c;
        msg_w[9]  = 32'h6a6b6c6d; msg_w[10] = 32'h6b6c6d6e; msg_w[11] = 32'h6c6d6e6f;
        msg_w[12] = 32'h6d6e6f70; msg_w[13] = 32'h6e6f7071;
        load_msg("two_blk", 448, 14, 1'b0);
        finish_msg("two_blk", 448, 1'b0, 1'b1,
                   256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

        // Reset while round 30 of the first block is being computed.
        msg_w[0] = 32'h61626300;
        load_msg("midrst", 24, 1, 1'b0);
        repeat (31) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst:state", 256'(state), 256'(0));
        chk("midrst:fine", 256'(fine), 256'(0));
        chk("midrst:hash", HASH, 256'(0));
        reset = 1'b1; start = 1'b0;
        @(negedge clock);
        load_msg("rerun", 24, 1, 1'b0);
        finish_msg("rerun", 24, 1'b0, 1'b1,
                   256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        run_rand("r447", 447, 1'b0);
        run_rand("r448", 448, 1'b1);
        run_rand("r1983", 1983, 1'b0);
        run_rand("r_one", $urandom_range(0, 447), 1'b0);
        run_rand("r_two", $urandom_range(448, 959), 1'b1);
        run_rand("r_four", $urandom_range(960, 1983), 1'b0);

        // Oversized length: block count clamps and the run still finishes; digest is don't-care.
        for (int i = 0; i < 64; i++) msg_w[i] = $urandom;
        load_msg("overlen", 2500, 64, 1'b0);
        finish_msg("overlen", 2500, 1'b0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
